msg_sched_param: RTL
====================

// Module: msg_sched_param
// PURPOSE
//  Parametrised SHA-2 message scheduler. Expands one 16-word block into ROUNDS
//  schedule words W[0..ROUNDS-1] for the compression core.
//  Generalises the fixed SHA-256 scheduler:
//   - WORD_W selects SHA-256 (32) or SHA-384/512 (64).
//   - valid/ready handshakes on both sides, with back-pressure.
//   - Abort, and back-to-back block reload.
// PARAMETERS
//  WORD_W  32  word width; only 32 or 64 are legal, anything else is an elaboration error
//  ROUNDS  64  schedule length; use 64 for WORD_W=32 and 80 for WORD_W=64; must be >16
//  IDX_W   $clog2(ROUNDS)  width of w_idx (derived; do not override)
// PORTS
//  clk        in   1         clock, rising edge
//  rst        in   1         asynchronous, active-low reset
//  blk_valid  in   1         block offered
//  blk_ready  out  1         scheduler can accept a block
//  block      in   16*WORD_W message block; word 0 = block[16*WORD_W-1 -: WORD_W] (big-endian)
//  blk_final  in   1         sideband: last block of the message; captured with block
//  abort      in   1         synchronous flush to IDLE
//  w          out  WORD_W    current schedule word W[t]
//  w_idx      out  IDX_W     t
//  w_valid    out  1         w/w_idx valid
//  w_ready    in   1         consumer takes w this cycle
//  w_last     out  1         t == ROUNDS-1
//  msg_final  out  1         captured blk_final; meaningful only while w_valid
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, window=0, t=0, w_valid=0, w_last=0,
//   msg_final=0, w=0, w_idx=0. blk_ready=1 once reset is released.
//  Window: 16 x WORD_W registers win[0..15] holding W[t..t+15]; w = win[0].
//  States:
//   IDLE: blk_ready=1, w_valid=0.
//     On blk_valid&blk_ready: load win <= block words, t=0, latch blk_final -> RUN.
//   RUN: w_valid=1.
//     On w_valid&w_ready with t<ROUNDS-1: shift win down by one; win[15] <= nxt; t++.
//     On the transfer with t==ROUNDS-1 (w_last): go to IDLE, or reload directly if
//       blk_valid is high (see blk_ready below).
//  nxt = s1(win[14]) + win[9] + s0(win[1]) + win[0], computed mod 2^WORD_W; carries dropped.
//  Sigma functions:
//   WORD_W=32: s0 = ROTR7^ROTR18^SHR3;  s1 = ROTR17^ROTR19^SHR10
//   WORD_W=64: s0 = ROTR1^ROTR8^SHR7;   s1 = ROTR19^ROTR61^SHR6
//  Latency: block accepted at edge N -> W[0] valid after edge N, i.e. in cycle N+1.
//   With w_ready held high, one word per cycle and W[ROUNDS-1] in cycle N+ROUNDS.
//  Back-pressure: while w_valid&!w_ready, w, w_idx, w_last, msg_final and the window
//   are held stable.
//  blk_ready = IDLE | (w_valid & w_ready & w_last).
//   A block offered in the same cycle as the final transfer is loaded at that edge,
//   so there is no bubble between blocks.
//  w_last = RUN & (t==ROUNDS-1).
//  abort (sampled at the edge) -> IDLE, w_valid=0, t=0. abort has priority over
//   every transfer and load in that cycle; a block offered that cycle is not accepted.
//  blk_valid while RUN and not on the final transfer: ignored; blk_ready=0.
//  Reset asserted mid-block: immediate return to reset values; no partial word is
//   presented after release.
// STRUCTURE
//  Package sha2_pkg:
//   - functions sig0/sig1, selected by WORD_W
//   - localparams for the rotate/shift amounts of both widths
//   - state enum {IDLE, RUN}
//  Sub-module sha2_msg_expand (combinational): inputs win[0],win[1],win[9],win[14];
//   output nxt. Reusable by a future multi-lane variant.
//  Top: FSM, t counter, 16-word shift window, output registers.
// TESTING
//  1 WORD_W=32, block "abc" (0x61626380, 14 zero words, 0x00000018), w_ready=1
//    -> W0=61626380, W15=00000018, W16=61626380, W17=000F0000, W18=7DA86405,
//       W19=600003C6; w_last only at idx 63; blk_ready back to 1 one cycle later.
//  2 WORD_W=64, ROUNDS=80, "abc" block -> W0=6162638000000000, W16=6162638000000000,
//    W17=00030000000000C0; w_last at idx 79.
//  3 Back-pressure: drop w_ready for 3 cycles at idx 17 (case 1)
//    -> w=000F0000 and w_idx=17 held stable; sequence then resumes with W18=7DA86405.
//  4 Back-to-back: second block offered during the idx-63 transfer
//    -> accepted that edge; next cycle w_idx=0 with the new W0, no bubble;
//       msg_final follows the new blk_final.
//  5 abort at idx 30 -> next cycle w_valid=0, blk_ready=1; a new block then restarts at idx 0.
//  6 rst low at idx 40 -> w_valid=0, w=0 asynchronously; after release, IDLE with blk_ready=1.

Source files
------------

// File: rtl/sha2_pkg.sv
// Shared SHA-2 definitions: scheduler state encoding, sigma rotate/shift amounts
// and the small-sigma functions for both the 32-bit and 64-bit word widths.
package sha2_pkg;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} sched_state_t;

  localparam int S256_S0_R0 = 7;
  localparam int S256_S0_R1 = 18;
  localparam int S256_S0_SH = 3;
  localparam int S256_S1_R0 = 17;
  localparam int S256_S1_R1 = 19;
  localparam int S256_S1_SH = 10;

  localparam int S512_S0_R0 = 1;
  localparam int S512_S0_R1 = 8;
  localparam int S512_S0_SH = 7;
  localparam int S512_S1_R0 = 19;
  localparam int S512_S1_R1 = 61;
  localparam int S512_S1_SH = 6;

  function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // 32-bit results come back zero-extended in the low half of a 64-bit value
  function automatic logic [63:0] sig0(input logic [63:0] x, input int word_w);
    logic [63:0] r;
    if (word_w == 32)
      r = {32'h0, rotr32(x[31:0], S256_S0_R0) ^ rotr32(x[31:0], S256_S0_R1)
                  ^ (x[31:0] >> S256_S0_SH)};
    else
      r = rotr64(x, S512_S0_R0) ^ rotr64(x, S512_S0_R1) ^ (x >> S512_S0_SH);
    return r;
  endfunction

  function automatic logic [63:0] sig1(input logic [63:0] x, input int word_w);
    logic [63:0] r;
    if (word_w == 32)
      r = {32'h0, rotr32(x[31:0], S256_S1_R0) ^ rotr32(x[31:0], S256_S1_R1)
                  ^ (x[31:0] >> S256_S1_SH)};
    else
      r = rotr64(x, S512_S1_R0) ^ rotr64(x, S512_S1_R1) ^ (x >> S512_S1_SH);
    return r;
  endfunction

endpackage

// File: rtl/sha2_msg_expand.sv
// Combinational SHA-2 schedule recurrence: next word from the four taps of the
// 16-word window, modulo 2^WORD_W.
module sha2_msg_expand
  import sha2_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic [WORD_W-1:0] w0,
  input  logic [WORD_W-1:0] w1,
  input  logic [WORD_W-1:0] w9,
  input  logic [WORD_W-1:0] w14,
  output logic [WORD_W-1:0] nxt
);

  always_comb begin
    nxt = WORD_W'(sig1(64'(w14), WORD_W)) + w9 + WORD_W'(sig0(64'(w1), WORD_W)) + w0;
  end

endmodule

// File: rtl/msg_sched_param.sv
// Parametrised SHA-2 message scheduler: expands a 16-word block into ROUNDS
// schedule words with valid/ready on both sides, abort and gapless block reload.
module msg_sched_param
  import sha2_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64,
  parameter int IDX_W  = $clog2(ROUNDS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 blk_valid,
  output logic                 blk_ready,
  input  logic [16*WORD_W-1:0] block,
  input  logic                 blk_final,
  input  logic                 abort,
  output logic [WORD_W-1:0]    w,
  output logic [IDX_W-1:0]     w_idx,
  output logic                 w_valid,
  input  logic                 w_ready,
  output logic                 w_last,
  output logic                 msg_final
);

  generate
    if (!(WORD_W == 32 || WORD_W == 64)) begin : g_bad_word_w
      $error("msg_sched_param: WORD_W must be 32 or 64");
    end
    if (ROUNDS <= 16) begin : g_bad_rounds
      $error("msg_sched_param: ROUNDS must be greater than 16");
    end
  endgenerate

  sched_state_t      state;
  logic [WORD_W-1:0] win [16];
  logic [IDX_W-1:0]  t;
  logic              fin;
  logic [WORD_W-1:0] nxt;
  logic              load;
  logic              xfer;

  sha2_msg_expand #(.WORD_W(WORD_W)) u_expand (
    .w0  (win[0]),
    .w1  (win[1]),
    .w9  (win[9]),
    .w14 (win[14]),
    .nxt (nxt)
  );

  assign w         = win[0];
  assign w_idx     = t;
  assign w_valid   = (state == RUN);
  assign w_last    = w_valid && (t == IDX_W'(ROUNDS - 1));
  assign msg_final = fin;
  // the final transfer frees the window, so a waiting block can load on that same edge
  assign blk_ready = (state == IDLE) || (w_valid && w_ready && w_last);
  assign load      = blk_valid && blk_ready && !abort;
  assign xfer      = w_valid && w_ready && !abort;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      t     <= '0;
      fin   <= 1'b0;
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else if (abort) begin
      state <= IDLE;
      t     <= '0;
    end else if (load) begin
      state <= RUN;
      t     <= '0;
      fin   <= blk_final;
      for (int i = 0; i < 16; i++) win[i] <= block[(16-i)*WORD_W-1 -: WORD_W];
    end else if (xfer) begin
      if (w_last) begin
        state <= IDLE;
        t     <= '0;
      end else begin
        t <= t + IDX_W'(1);
        for (int i = 0; i < 15; i++) win[i] <= win[i+1];
        win[15] <= nxt;
      end
    end
  end

endmodule
